dshift_buf: RTL

Parametrised bidirectional shift buffer with per-lane valid tracking, rotation, parallel load/clear, occupancy count and a registered shift-out port. It is the general-purpose successor to the plain direction-select shift register and is used wherever matrix rows or columns are streamed in and out of the EKF datapath word by word. All outputs are registered.

---
 rtl/dshift_buf.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dshift_buf.sv
// Bidirectional lane shift buffer with per-lane valid, rotate, parallel load/clear and an eject port.
// Latency 1 cycle for every operation; no backpressure, a new operation is accepted every cycle.
module dshift_buf #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2:0]            mode,
    input  logic [DW-1:0]         din,
    input  logic                  din_valid,
    input  logic [DW*DEPTH-1:0]   pdin,
    input  logic [DEPTH-1:0]      pvld,
    output logic [DW*DEPTH-1:0]   dout,
    output logic [DEPTH-1:0]      vld,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic [DW-1:0]         so_data,
    output logic                  so_valid,
    output logic                  err
);

    localparam logic [2:0] MODE_HOLD     = 3'd0;
    localparam logic [2:0] MODE_SHIFT_UP = 3'd1;
    localparam logic [2:0] MODE_SHIFT_DN = 3'd2;
    localparam logic [2:0] MODE_ROT_UP   = 3'd3;
    localparam logic [2:0] MODE_ROT_DN   = 3'd4;
    localparam logic [2:0] MODE_LOAD     = 3'd5;
    localparam logic [2:0] MODE_CLEAR    = 3'd6;

    typedef logic [DEPTH-1:0][DW-1:0] lanes_t;

    lanes_t           lane_q, lane_n;
    logic [DEPTH-1:0] vld_q, vld_n;
    logic [CW-1:0]    count_q, count_n;
    logic             full_q, empty_q;
    logic [DW-1:0]    so_data_q, so_data_n;
    logic             so_valid_q, so_valid_n;
    logic             err_q, err_n;

    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        lane_n     = lane_q;
        vld_n      = vld_q;
        so_data_n  = so_data_q;
        so_valid_n = 1'b0;
        err_n      = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                end
                MODE_SHIFT_UP: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        lane_n[i] = lane_q[i-1];
                    end
                    lane_n[0]  = din;
                    vld_n      = {vld_q[DEPTH-2:0], din_valid};
                    so_data_n  = lane_q[DEPTH-1];
                    so_valid_n = vld_q[DEPTH-1];
                end
                MODE_SHIFT_DN: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        lane_n[i] = lane_q[i+1];
                    end
                    lane_n[DEPTH-1] = din;
                    vld_n           = {din_valid, vld_q[DEPTH-1:1]};
                    so_data_n       = lane_q[0];
                    so_valid_n      = vld_q[0];
                end
                MODE_ROT_UP: begin
                    for (int i = 1; i < DEPTH; i++) begin
                        lane_n[i] = lane_q[i-1];
                    end
                    lane_n[0] = lane_q[DEPTH-1];
                    vld_n     = {vld_q[DEPTH-2:0], vld_q[DEPTH-1]};
                end
                MODE_ROT_DN: begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        lane_n[i] = lane_q[i+1];
                    end
                    lane_n[DEPTH-1] = lane_q[0];
                    vld_n           = {vld_q[0], vld_q[DEPTH-1:1]};
                end
                MODE_LOAD: begin
                    lane_n = pdin;
                    vld_n  = pvld;
                end
                MODE_CLEAR: begin
                    lane_n = '0;
                    vld_n  = '0;
                end
                default: begin
                    err_n = 1'b1;
                end
            endcase
        end
        // Count tracks the next valid vector so it never lags vld by a cycle.
        count_n = popcount(vld_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q     <= '0;
            vld_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            so_data_q  <= '0;
            so_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            lane_q     <= lane_n;
            vld_q      <= vld_n;
            count_q    <= count_n;
            full_q     <= (count_n == CW'(DEPTH));
            empty_q    <= (count_n == '0);
            so_data_q  <= so_data_n;
            so_valid_q <= so_valid_n;
            err_q      <= err_n;
        end
    end

    assign dout     = lane_q;
    assign vld      = vld_q;
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign so_data  = so_data_q;
    assign so_valid = so_valid_q;
    assign err      = err_q;

endmodule
